// File: rtl/line_window_3x3.sv
// line_window_3x3
//
// Sliding 3x3 neighbourhood generator for a square raster-order pixel stream.
// The two previous image rows are held in line buffers. A 3x3 register window
// shifts left by one column on every accepted pixel. One flattened window is
// emitted per valid output position ((IMG_W-2)^2 per frame), one cycle after
// the pixel that completes it.
//
// Ports:
//   iClk         clock, all logic on the rising edge
//   iRst         synchronous active-high reset
//   iPixelIn     pixel data, unsigned, raster order
//   iPixelValid  pixel accept strobe (no backpressure)
//   oWinValid    one-cycle pulse per emitted window
//   oWin         window, slice [PIX_W*(3*i+j) +: PIX_W] = pixel(r-2+i, c-2+j)
//   oRow         output-map row of oWin
//   oCol         output-map column of oWin
//   oFrameDone   pulse coinciding with the last window of a frame

module line_window_3x3 #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned PIX_W = 8,
    localparam int unsigned W = IMG_W - 2
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [PIX_W-1:0]     iPixelIn,
    input  logic                 iPixelValid,
    output logic                 oWinValid,
    output logic [9*PIX_W-1:0]   oWin,
    output logic [$clog2(W)-1:0] oRow,
    output logic [$clog2(W)-1:0] oCol,
    output logic                 oFrameDone
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned OW = $clog2(W);

    // Position of the pixel that will be accepted next.
    logic [CW-1:0]    r_col_cnt;
    logic [CW-1:0]    r_row_cnt;

    // r_lbuf0 holds the previous row, r_lbuf1 the row before that.
    logic [PIX_W-1:0] r_lbuf0 [IMG_W];
    logic [PIX_W-1:0] r_lbuf1 [IMG_W];

    // r_win[i][j]: i = 0 is the oldest row, j = 2 the newest column.
    logic [PIX_W-1:0] r_win [3][3];

    logic             r_win_valid;
    logic             r_frame_done;
    logic [OW-1:0]    r_out_row;
    logic [OW-1:0]    r_out_col;

    logic             w_col_last;
    logic             w_row_last;
    logic             w_stream;
    logic             w_emit;
    logic [CW-1:0]    w_row_m2;
    logic [CW-1:0]    w_col_m2;
    logic [9*PIX_W-1:0] w_win_flat;

    assign w_col_last = (r_col_cnt == CW'(IMG_W - 1));
    assign w_row_last = (r_row_cnt == CW'(IMG_W - 1));

    // FILL phase is rows 0 and 1; windows only exist from row 2 on.
    assign w_stream   = (r_row_cnt >= CW'(2));

    // Columns 0 and 1 would produce windows straddling the row wrap.
    assign w_emit     = iPixelValid && w_stream && (r_col_cnt >= CW'(2));

    assign w_row_m2   = r_row_cnt - CW'(2);
    assign w_col_m2   = r_col_cnt - CW'(2);

    // Position counters, window registers and output strobes.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_col_cnt    <= '0;
            r_row_cnt    <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (iPixelValid) begin
                if (w_col_last) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_last ? '0 : r_row_cnt + CW'(1);
                end else begin
                    r_col_cnt <= r_col_cnt + CW'(1);
                end

                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                // Buffers are read before this cycle's write lands.
                r_win[0][2] <= r_lbuf1[r_col_cnt];
                r_win[1][2] <= r_lbuf0[r_col_cnt];
                r_win[2][2] <= iPixelIn;

                if (w_emit) begin
                    r_win_valid  <= 1'b1;
                    r_out_row    <= w_row_m2[OW-1:0];
                    r_out_col    <= w_col_m2[OW-1:0];
                    r_frame_done <= w_row_last && w_col_last;
                end
            end
        end
    end

    // Line buffers carry no reset; a dropped pixel (reset cycle) is not written.
    always_ff @(posedge iClk) begin
        if (!iRst && iPixelValid) begin
            r_lbuf1[r_col_cnt] <= r_lbuf0[r_col_cnt];
            r_lbuf0[r_col_cnt] <= iPixelIn;
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win_flat[PIX_W*(3*i+j) +: PIX_W] = r_win[i][j];
            end
        end
    end

    assign oWinValid  = r_win_valid;
    assign oWin       = w_win_flat;
    assign oRow       = r_out_row;
    assign oCol       = r_out_col;
    assign oFrameDone = r_frame_done;

endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3
//
// Directed bench for line_window_3x3 (IMG_W=28, PIX_W=8). Ramp frames are
// streamed pixel by pixel; after every accept and every idle cycle the outputs
// are compared against windows computed directly from the ramp formula.

module tb_line_window_3x3;

    localparam int IMG = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic        pv;
    logic [7:0]  pin;
    logic        wv;
    logic [71:0] win;
    logic [4:0]  orow;
    logic [4:0]  ocol;
    logic        fd;

    int n_pass  = 0;
    int n_total = 0;
    int win_cnt = 0;
    int fd_cnt  = 0;

    always #5 clk = ~clk;

    line_window_3x3 #(
        .IMG_W(28),
        .PIX_W(8)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iPixelIn   (pin),
        .iPixelValid(pv),
        .oWinValid  (wv),
        .oWin       (win),
        .oRow       (orow),
        .oCol       (ocol),
        .oFrameDone (fd)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pix(input int r, input int c, input int off);
        return 8'((r * IMG + c + off) & 255);
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c, input int off);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[8*(3*i+j) +: 8] = pix(r - 2 + i, c - 2 + j, off);
            end
        end
        return w;
    endfunction

    // One idle cycle: no strobe, window held.
    task automatic idle_cycle();
        logic [71:0] prev;
        prev = win;
        pv   = 1'b0;
        @(posedge clk);
        #1;
        chk("gap_valid", {71'd0, wv}, 72'd0);
        chk("gap_hold", win, prev);
        chk("gap_done", {71'd0, fd}, 72'd0);
    endtask

    // One accepted pixel at (r,c), then check the cycle after.
    task automatic accept(input int r, input int c, input int off);
        bit emit;
        bit last;
        pin = pix(r, c, off);
        pv  = 1'b1;
        @(posedge clk);
        #1;
        pv   = 1'b0;
        emit = (r >= 2) && (c >= 2);
        last = (r == IMG - 1) && (c == IMG - 1);
        if (wv) win_cnt++;
        if (fd) fd_cnt++;
        chk("win_valid", {71'd0, wv}, {71'd0, emit});
        chk("frame_done", {71'd0, fd}, {71'd0, last});
        if (emit) begin
            chk("win_data", win, exp_win(r, c, off));
            chk("win_row", {67'd0, orow}, 72'(r - 2));
            chk("win_col", {67'd0, ocol}, 72'(c - 2));
        end
    endtask

    task automatic send_frame(input int off, input int max_gap);
        for (int r = 0; r < IMG; r++) begin
            for (int c = 0; c < IMG; c++) begin
                if (max_gap > 0) begin
                    repeat ($urandom_range(0, max_gap)) idle_cycle();
                end
                accept(r, c, off);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pv  = 1'b0;
        pin = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {71'd0, wv}, 72'd0);
        chk("rst_done", {71'd0, fd}, 72'd0);
        chk("rst_win", win, 72'd0);
        chk("rst_row", {67'd0, orow}, 72'd0);
        chk("rst_col", {67'd0, ocol}, 72'd0);
        rst = 1'b0;

        // Continuous ramp frame.
        win_cnt = 0;
        fd_cnt  = 0;
        send_frame(0, 0);
        chk("s1_win_count", 72'(win_cnt), 72'd676);
        chk("s1_done_count", 72'(fd_cnt), 72'd1);
        chk("s1_last_slice8", {64'd0, win[71:64]}, 72'h0F);

        // Same ramp with random idle gaps.
        win_cnt = 0;
        fd_cnt  = 0;
        send_frame(0, 5);
        chk("s2_win_count", 72'(win_cnt), 72'd676);
        chk("s2_done_count", 72'(fd_cnt), 72'd1);

        // Two frames back to back, second offset by 0x80.
        win_cnt = 0;
        fd_cnt  = 0;
        send_frame(0, 0);
        send_frame(128, 0);
        chk("s3_win_count", 72'(win_cnt), 72'd1352);
        chk("s3_done_count", 72'(fd_cnt), 72'd2);

        // Reset mid-frame after pixel 400, then a fresh frame.
        for (int k = 0; k <= 400; k++) accept(k / IMG, k % IMG, 0);
        rst = 1'b1;
        pv  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("s4_rst_valid", {71'd0, wv}, 72'd0);
        chk("s4_rst_done", {71'd0, fd}, 72'd0);
        chk("s4_rst_win", win, 72'd0);
        win_cnt = 0;
        fd_cnt  = 0;
        send_frame(0, 0);
        chk("s4_win_count", 72'(win_cnt), 72'd676);
        chk("s4_done_count", 72'(fd_cnt), 72'd1);

        // Reset coincident with a valid pixel: that pixel is dropped.
        for (int k = 0; k < 10; k++) accept(0, k, 0);
        rst = 1'b1;
        pv  = 1'b1;
        pin = 8'hAA;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pv  = 1'b0;
        chk("s5_rst_valid", {71'd0, wv}, 72'd0);
        chk("s5_col_cnt", {67'd0, dut.r_col_cnt}, 72'd0);
        chk("s5_row_cnt", {67'd0, dut.r_row_cnt}, 72'd0);
        win_cnt = 0;
        fd_cnt  = 0;
        send_frame(0, 0);
        chk("s5_win_count", 72'(win_cnt), 72'd676);
        chk("s5_done_count", 72'(fd_cnt), 72'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
